// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris core timing logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tetris_pkg;

  localparam int LEVEL_W = 4;
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUNNING = 2'd1;
  localparam state_t ST_PAUSED  = 2'd2;
  localparam state_t ST_OVER    = 2'd3;

endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// Prescaler that emits a one-cycle tick every `period` enabled cycles.
// Latency: tick is registered, one cycle after the counter reaches period-1.
// Backpressure: none; en holds the count, clr zeroes it.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   en           count enable (counter holds while low)
//   clr          zero the counter and drop any tick (wins over en)
//   period       tick period in enabled cycles, may change at any time
//   tick         registered one-cycle strobe
module tick_divider #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             at_end;

  // One extra bit so cnt+1 never wraps and a zero period cannot underflow.
  // The >= test lets a shortened period fire on the next enabled cycle
  // instead of running the counter all the way round.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign at_end  = cnt_inc >= {1'b0, period};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (at_end) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt_inc[CNT_W-1:0];
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game-phase FSM plus the 1 Hz timekeeper strobe and level-paced gravity strobe.
// Latency: state/clr_time/ticks all registered; a button edge acts one cycle later.
// Backpressure: none; ticks are only produced while RUNNING and freeze otherwise.
// Build option: define SOFT_DROP_EN to add the soft_drop port and fast gravity.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   start, pause debounced buttons (levels; only rising edges act)
//   game_over    playfield topped out
//   level        current level 0..15
//   soft_drop    held soft-drop button (SOFT_DROP_EN builds only)
//   state        0=IDLE 1=RUNNING 2=PAUSED 3=OVER
//   running      state == RUNNING
//   clr_time     one-cycle pulse when a new game begins
//   sec_tick     one-cycle pulse every CLK_HZ running cycles
//   drop_tick    one-cycle pulse every gravity period of running cycles
module game_tick_scheduler
  import tetris_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DROP_BASE = 50_000_000,
  parameter int DROP_STEP = 3_000_000,
  parameter int DROP_MIN  = 5_000_000,
`ifdef SOFT_DROP_EN
  parameter int DROP_FAST = 2_500_000,
`endif
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause,
  input  logic               game_over,
  input  logic [LEVEL_W-1:0] level,
`ifdef SOFT_DROP_EN
  input  logic               soft_drop,
`endif
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               clr_time,
  output logic               sec_tick,
  output logic               drop_tick
);

  localparam int PW = CNT_W + 4;
  localparam logic [CNT_W-1:0] SEC_PERIOD = CNT_W'(CLK_HZ);
  localparam logic [PW-1:0]    BASE_W     = PW'(DROP_BASE);
  localparam logic [PW-1:0]    STEP_W     = PW'(DROP_STEP);
  localparam logic [PW-1:0]    MIN_W      = PW'(DROP_MIN);

  state_t           state_nxt;
  logic             start_q, pause_q;
  logic             start_edge, pause_edge;
  logic             new_game;
  logic             count_en;
  logic [PW-1:0]    step_prod, base_sub, lvl_period_w;
  logic [CNT_W-1:0] lvl_period, drop_period;

  // ---------------- button edge detect ----------------
  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;

  // ---------------- phase FSM ----------------
  // game_over only matters mid-game; in IDLE/OVER a held game_over must not
  // block a restart, so start is evaluated there regardless of it.
  always_comb begin
    state_nxt = state;
    new_game  = 1'b0;
    if (game_over && (state == ST_RUNNING || state == ST_PAUSED)) begin
      state_nxt = ST_OVER;
    end else if (start_edge && (state == ST_IDLE || state == ST_OVER)) begin
      state_nxt = ST_RUNNING;
      new_game  = 1'b1;
    end else if (pause_edge && state == ST_RUNNING) begin
      state_nxt = ST_PAUSED;
    end else if (pause_edge && state == ST_PAUSED) begin
      state_nxt = ST_RUNNING;
    end
  end

  // Count only cycles that start and end in RUNNING: the cycle that leaves
  // RUNNING must neither advance the count nor launch a tick that would land
  // in PAUSED/OVER, which keeps a resumed second exactly the remaining length.
  assign count_en = (state == ST_RUNNING) && (state_nxt == ST_RUNNING);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      clr_time <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      pause_q  <= pause;
      clr_time <= new_game;
    end
  end

  assign running = (state == ST_RUNNING);

  // ---------------- gravity period ----------------
  // Widened by 4 bits so level*step cannot overflow; the difference
  // saturates at zero before the floor is applied.
  assign step_prod    = PW'(level) * STEP_W;
  assign base_sub     = (step_prod >= BASE_W) ? '0 : (BASE_W - step_prod);
  assign lvl_period_w = (base_sub < MIN_W) ? MIN_W : base_sub;
  assign lvl_period   = (|lvl_period_w[PW-1:CNT_W]) ? '1 : lvl_period_w[CNT_W-1:0];

`ifdef SOFT_DROP_EN
  localparam logic [CNT_W-1:0] FAST_PERIOD = CNT_W'(DROP_FAST);
  assign drop_period = (soft_drop && state == ST_RUNNING && lvl_period > FAST_PERIOD)
                       ? FAST_PERIOD : lvl_period;
`else
  assign drop_period = lvl_period;
`endif

  // ---------------- prescalers ----------------
  tick_divider #(.CNT_W(CNT_W)) u_sec_div (
    .clk    (clk),
    .resetn (resetn),
    .en     (count_en),
    .clr    (new_game),
    .period (SEC_PERIOD),
    .tick   (sec_tick)
  );

  tick_divider #(.CNT_W(CNT_W)) u_drop_div (
    .clk    (clk),
    .resetn (resetn),
    .en     (count_en),
    .clr    (new_game),
    .period (drop_period),
    .tick   (drop_tick)
  );

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler with small prescaler periods.
// Expected pulse cycles are queued as stimulus is driven and retired by a
// negedge monitor; FSM state is checked directly after each transition.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] level = 4'd0;
`ifdef SOFT_DROP_EN
  logic       soft_drop = 1'b0;
`endif
  logic [1:0] state;
  logic       running, clr_time, sec_tick, drop_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0;
  int sec_q[$];
  int drop_q[$];
  int clr_q[$];

  game_tick_scheduler #(
    .CLK_HZ    (10),
    .DROP_BASE (20),
    .DROP_STEP (3),
    .DROP_MIN  (5),
`ifdef SOFT_DROP_EN
    .DROP_FAST (2),
`endif
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .pause     (pause),
    .game_over (game_over),
    .level     (level),
`ifdef SOFT_DROP_EN
    .soft_drop (soft_drop),
`endif
    .state     (state),
    .running   (running),
    .clr_time  (clr_time),
    .sec_tick  (sec_tick),
    .drop_tick (drop_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard queues (0=sec 1=drop 2=clr) ----------------
  function automatic int q_size(input int k);
    case (k)
      0:       return sec_q.size();
      1:       return drop_q.size();
      default: return clr_q.size();
    endcase
  endfunction

  function automatic int q_head(input int k);
    case (k)
      0:       return sec_q[0];
      1:       return drop_q[0];
      default: return clr_q[0];
    endcase
  endfunction

  function automatic int q_pop(input int k);
    case (k)
      0:       return sec_q.pop_front();
      1:       return drop_q.pop_front();
      default: return clr_q.pop_front();
    endcase
  endfunction

  task automatic q_push(input int k, input int t);
    case (k)
      0:       sec_q.push_back(t);
      1:       drop_q.push_back(t);
      default: clr_q.push_back(t);
    endcase
  endtask

  task automatic push_ticks(input int k, input int first, input int per, input int upto);
    for (int t = first; t <= upto; t += per) q_push(k, t);
  endtask

  task automatic scan(input int k, input string nm, input logic pulse);
    int exp_t;
    // Any expectation already in the past with no pulse was missed.
    while (q_size(k) > 0 && q_head(k) < cyc) begin
      exp_t = q_pop(k);
      chk($sformatf("%s_missed_at_%0d", nm, exp_t), 32'd0, 32'd1);
    end
    if (pulse === 1'b1) begin
      if (q_size(k) > 0) begin
        exp_t = q_pop(k);
        chk($sformatf("%s_cycle", nm), cyc, exp_t);
      end else begin
        chk($sformatf("%s_unexpected_at_%0d", nm, cyc), 32'd1, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    scan(0, "sec_tick", sec_tick);
    scan(1, "drop_tick", drop_tick);
    scan(2, "clr_time", clr_time);
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic new_game(output int t_run);
    start = 1'b1;
    t_run = cyc + 1;
    q_push(2, t_run);
    @(negedge clk);
    chk("start_state", state, 32'd1);
    chk("start_running", running, 32'd1);
    start = 1'b0;
  endtask

  task automatic end_game();
    game_over = 1'b1;
    @(negedge clk);
    chk("over_state", state, 32'd3);
    chk("over_running", running, 32'd0);
    game_over = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", state, 32'd0);
    chk("rst_running", running, 32'd0);
    chk("rst_clr", clr_time, 32'd0);
    chk("rst_sec", sec_tick, 32'd0);
    chk("rst_drop", drop_tick, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Level 0: sec every 10, drop every 20
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 45);
    push_ticks(1, t0 + 20, 20, t0 + 45);
    wait_to(t0 + 45);
    end_game();
    repeat (15) @(negedge clk);

    // Level 4: drop period 8
    level = 4'd4;
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 25);
    push_ticks(1, t0 + 8, 8, t0 + 25);
    wait_to(t0 + 25);
    end_game();

    // Level 15: 20-45 saturates, floor gives 5
    level = 4'd15;
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 22);
    push_ticks(1, t0 + 5, 5, t0 + 22);
    wait_to(t0 + 22);
    end_game();

    // Level 0 -> 15 with drop count at 12: fires on the next cycle
    level = 4'd0;
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 25);
    q_push(1, t0 + 13);
    q_push(1, t0 + 18);
    q_push(1, t0 + 23);
    wait_to(t0 + 12);
    level = 4'd15;
    wait_to(t0 + 25);
    end_game();

    // Pause at sec count 6 for 50 cycles, then resume
    level = 4'd0;
    new_game(t0);
    wait_to(t0 + 6);
    pause = 1'b1;
    @(negedge clk);
    chk("pause_state", state, 32'd2);
    chk("pause_running", running, 32'd0);
    pause = 1'b0;
    wait_to(t0 + 57);
    pause = 1'b1;
    @(negedge clk);
    chk("resume_state", state, 32'd1);
    pause = 1'b0;
    q_push(0, t0 + 62);
    q_push(0, t0 + 72);
    q_push(0, t0 + 82);
    q_push(1, t0 + 72);
    wait_to(t0 + 85);

    // game_over and pause edge in the same cycle: game_over wins
    game_over = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    chk("over_vs_pause_state", state, 32'd3);
    game_over = 1'b0;
    pause = 1'b0;
    repeat (30) @(negedge clk);
    chk("over_hold_state", state, 32'd3);

    // Restart from OVER, then reset mid-game
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 23);
    q_push(1, t0 + 20);
    wait_to(t0 + 23);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_state", state, 32'd0);
    chk("midrst_running", running, 32'd0);
    chk("midrst_sec", sec_tick, 32'd0);
    chk("midrst_drop", drop_tick, 32'd0);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    chk("postrst_idle", state, 32'd0);

`ifdef SOFT_DROP_EN
    // Soft drop at level 0: period 2, then back to 20 on release
    soft_drop = 1'b1;
    new_game(t0);
    push_ticks(1, t0 + 2, 2, t0 + 10);
    push_ticks(0, t0 + 10, 10, t0 + 52);
    wait_to(t0 + 10);
    soft_drop = 1'b0;
    q_push(1, t0 + 30);
    q_push(1, t0 + 50);
    wait_to(t0 + 52);
    end_game();
`else
    // Ticks resume only after a fresh start
    new_game(t0);
    push_ticks(0, t0 + 10, 10, t0 + 21);
    q_push(1, t0 + 20);
    wait_to(t0 + 21);
    end_game();
`endif

    repeat (5) @(negedge clk);
    chk("sec_q_left", sec_q.size(), 32'd0);
    chk("drop_q_left", drop_q.size(), 32'd0);
    chk("clr_q_left", clr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
